// File: rtl/vx_raster_quad_gen_pkg.sv
// Shared raster types for the quad generator: field widths, the latched block descriptor,
// and block geometry helpers.
package vx_raster_quad_gen_pkg;

  localparam int unsigned VX_RASTER_DIM_BITS = 16;
  localparam int unsigned VX_RASTER_PID_BITS = 16;
  localparam int unsigned RASTER_DATA_BITS   = 32;

  typedef logic [RASTER_DATA_BITS-1:0]   raster_data_t;
  typedef logic [VX_RASTER_DIM_BITS-1:0] raster_dim_t;

  // Per-block state held for the whole walk; c lives in the edge accumulators.
  typedef struct packed {
    logic [VX_RASTER_PID_BITS-1:0] pid;
    raster_dim_t                   xloc;
    raster_dim_t                   yloc;
    raster_dim_t                   xmin;
    raster_dim_t                   xmax;
    raster_dim_t                   ymin;
    raster_dim_t                   ymax;
    raster_data_t [2:0]            a;
    raster_data_t [2:0]            b;
  } quad_desc_t;

  function automatic int unsigned quads_per_row(input int unsigned block_logsize);
    return 32'd1 << (block_logsize - 32'd1);
  endfunction

  function automatic int unsigned groups_per_row(input int unsigned block_logsize,
                                                 input int unsigned num_quads);
    return quads_per_row(block_logsize) / num_quads;
  endfunction

endpackage

// File: rtl/vx_raster_edge_step.sv
// Incremental edge-equation accumulator: row_c tracks the value at the start of the current
// quad row, grp_c the value at the current group origin.
module vx_raster_edge_step
  import vx_raster_quad_gen_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step_x,
  input  logic         step_y,
  input  raster_data_t c_in,
  input  raster_data_t dx,
  input  raster_data_t dy,
  output raster_data_t grp_c_next
);

  raster_data_t row_c_q, row_c_d;
  raster_data_t grp_c_q, grp_c_d;

  always_comb begin
    row_c_d = row_c_q;
    grp_c_d = grp_c_q;
    if (load) begin
      row_c_d = c_in;
      grp_c_d = c_in;
    end else if (step_y) begin
      // A new row starts from the row accumulator, not from the last group.
      row_c_d = row_c_q + dy;
      grp_c_d = row_c_q + dy;
    end else if (step_x) begin
      grp_c_d = grp_c_q + dx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_c_q <= '0;
      grp_c_q <= '0;
    end else begin
      row_c_q <= row_c_d;
      grp_c_q <= grp_c_d;
    end
  end

  // Exposed pre-register so the output stage can register the group it describes.
  assign grp_c_next = grp_c_d;

endmodule

// File: rtl/vx_raster_quad_gen.sv
// Rasterizer quad generator: walks one block in raster order, emitting NUM_QUADS 2x2 quads per
// cycle with edge equations rebased to each quad origin.
module vx_raster_quad_gen
  import vx_raster_quad_gen_pkg::*;
#(
  parameter string       INSTANCE_ID   = "",
  parameter int unsigned NUM_QUADS     = 4,
  parameter int unsigned BLOCK_LOGSIZE = 4
) (
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic                                                     valid_in,
  output logic                                                     ready_in,
  input  logic [VX_RASTER_PID_BITS-1:0]                            pid_in,
  input  logic [VX_RASTER_DIM_BITS-1:0]                            xloc_in,
  input  logic [VX_RASTER_DIM_BITS-1:0]                            yloc_in,
  input  logic [VX_RASTER_DIM_BITS-1:0]                            xmin_in,
  input  logic [VX_RASTER_DIM_BITS-1:0]                            xmax_in,
  input  logic [VX_RASTER_DIM_BITS-1:0]                            ymin_in,
  input  logic [VX_RASTER_DIM_BITS-1:0]                            ymax_in,
  input  logic [2:0][2:0][RASTER_DATA_BITS-1:0]                    edges_in,
  output logic                                                     valid_out,
  input  logic                                                     ready_out,
  output logic                                                     last_out,
  output logic [VX_RASTER_PID_BITS-1:0]                            pid_out,
  output logic [VX_RASTER_DIM_BITS-1:0]                            xmin_out,
  output logic [VX_RASTER_DIM_BITS-1:0]                            xmax_out,
  output logic [VX_RASTER_DIM_BITS-1:0]                            ymin_out,
  output logic [VX_RASTER_DIM_BITS-1:0]                            ymax_out,
  output logic [NUM_QUADS-1:0][VX_RASTER_DIM_BITS-1:0]             xloc_out,
  output logic [NUM_QUADS-1:0][VX_RASTER_DIM_BITS-1:0]             yloc_out,
  output logic [NUM_QUADS-1:0][2:0][2:0][RASTER_DATA_BITS-1:0]     edges_out
);

  localparam int unsigned QPR  = quads_per_row(BLOCK_LOGSIZE);
  localparam int unsigned GPR  = groups_per_row(BLOCK_LOGSIZE, NUM_QUADS);
  localparam int unsigned GX_W = (GPR > 1) ? $clog2(GPR) : 1;
  localparam int unsigned GY_W = $clog2(QPR);

  typedef enum logic {StIdle, StWalk} state_e;

  state_e          state_q, state_d;
  logic [GX_W-1:0] gx_q, gx_d;
  logic [GY_W-1:0] gy_q, gy_d;
  quad_desc_t      desc_q, desc_d;
  logic            accept, advance, row_end, step_x, step_y, last_d, out_en;
  raster_data_t [2:0] grp_c;

  logic [NUM_QUADS-1:0][VX_RASTER_DIM_BITS-1:0]         xloc_d, yloc_d;
  logic [NUM_QUADS-1:0][2:0][2:0][RASTER_DATA_BITS-1:0] edges_d;

  assign ready_in = (state_q == StIdle) || (last_out && ready_out);
  assign accept   = valid_in && ready_in;
  assign advance  = (state_q == StWalk) && ready_out && !last_out;
  assign row_end  = (gx_q == GX_W'(GPR - 1));
  assign step_x   = advance && !row_end;
  assign step_y   = advance && row_end;
  assign out_en   = !(valid_out && !ready_out);

  always_comb begin
    state_d = state_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    desc_d  = desc_q;
    if (accept) begin
      state_d     = StWalk;
      gx_d        = '0;
      gy_d        = '0;
      desc_d.pid  = pid_in;
      desc_d.xloc = xloc_in;
      desc_d.yloc = yloc_in;
      desc_d.xmin = xmin_in;
      desc_d.xmax = xmax_in;
      desc_d.ymin = ymin_in;
      desc_d.ymax = ymax_in;
      for (int unsigned k = 0; k < 3; k++) begin
        desc_d.a[k] = edges_in[k][2];
        desc_d.b[k] = edges_in[k][1];
      end
    end else begin
      if ((state_q == StWalk) && last_out && ready_out) state_d = StIdle;
      if (step_x) gx_d = gx_q + 1'b1;
      if (step_y) begin
        gx_d = '0;
        gy_d = gy_q + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_edge
    vx_raster_edge_step u_edge_step (
      .clk        (clk),
      .reset      (reset),
      .load       (accept),
      .step_x     (step_x),
      .step_y     (step_y),
      .c_in       (edges_in[k][0]),
      .dx         (desc_q.a[k] << ($clog2(NUM_QUADS) + 1)),
      .dy         (desc_q.b[k] << 1),
      .grp_c_next (grp_c[k])
    );
  end

  assign last_d = (state_d == StWalk) && (gx_d == GX_W'(GPR - 1)) && (gy_d == GY_W'(QPR - 1));

  // Outputs are computed from next state so the group is registered alongside its counters.
  always_comb begin
    xloc_d  = '0;
    yloc_d  = '0;
    edges_d = '0;
    for (int unsigned q = 0; q < NUM_QUADS; q++) begin
      xloc_d[q] = desc_d.xloc + raster_dim_t'((32'(gx_d) * NUM_QUADS + q) << 1);
      yloc_d[q] = desc_d.yloc + raster_dim_t'(32'(gy_d) << 1);
      for (int unsigned k = 0; k < 3; k++) begin
        edges_d[q][k] = {desc_d.a[k], desc_d.b[k],
                         grp_c[k] + desc_d.a[k] * raster_data_t'(2 * q)};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      gx_q    <= '0;
      gy_q    <= '0;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      desc_q  <= desc_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      pid_out   <= '0;
      xmin_out  <= '0;
      xmax_out  <= '0;
      ymin_out  <= '0;
      ymax_out  <= '0;
      xloc_out  <= '0;
      yloc_out  <= '0;
      edges_out <= '0;
    end else if (out_en) begin
      valid_out <= (state_d == StWalk);
      last_out  <= last_d;
      pid_out   <= desc_d.pid;
      xmin_out  <= desc_d.xmin;
      xmax_out  <= desc_d.xmax;
      ymin_out  <= desc_d.ymin;
      ymax_out  <= desc_d.ymax;
      xloc_out  <= xloc_d;
      yloc_out  <= yloc_d;
      edges_out <= edges_d;
    end
  end

endmodule
